// File: rtl/calendar_counter_if.sv
// rtl/calendar_counter_if.sv - command and date bundle for the calendar counter
//
// Purpose: groups the tick/load command inputs, the external days-in-month
//          value and the registered date outputs of calendar_counter.
// Signals:
//   tick        one-cycle pulse, advance date by one day
//   load        one-cycle pulse, load date from load_* fields
//   load_year   year to load (0 = 2000)
//   load_month  month to load, 1..12
//   load_day    day to load, 1..31
//   load_wday   weekday to load, 0 = Sunday .. 6 = Saturday
//   dim         days in month for the current year/month outputs
//   year/month/day/wday  current date, registered
//   busy        high during the load-check cycle
//   year_wrap   one-cycle pulse when the year wraps to 0
// Modports: master drives commands and dim, slave is the counter.
interface calendar_counter_if;
    logic       tick;
    logic       load;
    logic [6:0] load_year;
    logic [6:0] load_month;
    logic [4:0] load_day;
    logic [2:0] load_wday;
    logic [4:0] dim;
    logic [6:0] year;
    logic [6:0] month;
    logic [4:0] day;
    logic [2:0] wday;
    logic       busy;
    logic       year_wrap;

    modport master (
        output tick, load, load_year, load_month, load_day, load_wday, dim,
        input  year, month, day, wday, busy, year_wrap
    );

    modport slave (
        input  tick, load, load_year, load_month, load_day, load_wday, dim,
        output year, month, day, wday, busy, year_wrap
    );
endinterface

// File: rtl/calendar_counter.sv
// rtl/calendar_counter.sv - day/month/year/weekday counter with load and check
//
// Purpose: keeps a calendar date that advances one day per tick. A load
//          captures a sanitised date and spends one CHECK cycle clamping the
//          day to the days-in-month value supplied externally on bus.dim.
//          Ticks that collide with a load or arrive during CHECK are held in
//          a single pending flag and applied on the first IDLE cycle after.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    calendar_counter_if.slave (commands in, date out)
// Parameters:
//   YEAR_MAX  highest year value before wrapping to 0
module calendar_counter #(
    parameter int YEAR_MAX = 99
) (
    input  logic               clk,
    input  logic               rst_n,
    calendar_counter_if.slave  bus
);

    localparam logic [6:0] YMAX = 7'(YEAR_MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic [6:0] year_q;
    logic [6:0] month_q;
    logic [4:0] day_q;
    logic [2:0] wday_q;
    logic       wrap_q;
    logic       pending_q;

    // Next date if an advance happens this cycle.
    logic [6:0] adv_year;
    logic [6:0] adv_month;
    logic [4:0] adv_day;
    logic [2:0] adv_wday;
    logic       adv_wrap;

    // Sanitised load fields.
    logic [6:0] san_year;
    logic [6:0] san_month;
    logic [4:0] san_day;
    logic [2:0] san_wday;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: a load in IDLE always costs exactly one CHECK cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.load) state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy = 1'b0;
        if (state_q == CHECK) bus.busy = 1'b1;
    end

    assign bus.year      = year_q;
    assign bus.month     = month_q;
    assign bus.day       = day_q;
    assign bus.wday      = wday_q;
    assign bus.year_wrap = wrap_q;

    // ------------------------------------------------------------------
    // Date advance. Rolling on day >= dim (not ==) means an out-of-range
    // day still rolls into the next month instead of counting upward.
    // ------------------------------------------------------------------
    always_comb begin
        adv_year  = year_q;
        adv_month = month_q;
        adv_day   = day_q + 5'd1;
        adv_wrap  = 1'b0;
        if (day_q >= bus.dim) begin
            adv_day = 5'd1;
            if (month_q >= 7'd12) begin
                adv_month = 7'd1;
                if (year_q >= YMAX) begin
                    adv_year = 7'd0;
                    adv_wrap = 1'b1;
                end else begin
                    adv_year = year_q + 7'd1;
                end
            end else begin
                adv_month = month_q + 7'd1;
            end
        end
        adv_wday = (wday_q >= 3'd6) ? 3'd0 : wday_q + 3'd1;
    end

    // ------------------------------------------------------------------
    // Load sanitising
    // ------------------------------------------------------------------
    always_comb begin
        san_year  = (bus.load_year > YMAX) ? 7'd0 : bus.load_year;
        san_month = (bus.load_month == 7'd0 || bus.load_month > 7'd12) ? 7'd1 : bus.load_month;
        san_day   = (bus.load_day == 5'd0) ? 5'd1 : bus.load_day;
        san_wday  = (bus.load_wday > 3'd6) ? 3'd0 : bus.load_wday;
    end

    // ------------------------------------------------------------------
    // Date, wrap pulse and pending-tick registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            year_q    <= 7'd0;
            month_q   <= 7'd1;
            day_q     <= 5'd1;
            wday_q    <= 3'd6;
            wrap_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        // A load wins over any advance; a pending tick stays
                        // pending and is applied once the new CHECK is done.
                        year_q  <= san_year;
                        month_q <= san_month;
                        day_q   <= san_day;
                        wday_q  <= san_wday;
                        if (bus.tick) pending_q <= 1'b1;
                    end else if (pending_q || bus.tick) begin
                        year_q  <= adv_year;
                        month_q <= adv_month;
                        day_q   <= adv_day;
                        wday_q  <= adv_wday;
                        wrap_q  <= adv_wrap;
                        // The held tick goes first; a fresh tick in the same
                        // cycle becomes the new pending one.
                        if (pending_q) pending_q <= bus.tick;
                    end
                end
                CHECK: begin
                    if (day_q > bus.dim) day_q <= bus.dim;
                    if (bus.tick) pending_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calendar_counter.sv
// tb/tb_calendar_counter.sv - scoreboard bench for calendar_counter
module tb_calendar_counter;

    logic clk;
    logic rst_n;

    calendar_counter_if bus ();

    calendar_counter #(.YEAR_MAX(99)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int year;
        int month;
        int day;
        int wday;
        int busy;
        int wrap;
    } exp_t;

    exp_t sb[$];

    int checks;
    int failures;

    // External days-in-month lookup; dim_ovr lets the bench present an
    // inconsistent dim to exercise the defensive roll in IDLE.
    logic       dim_ovr;
    logic [4:0] dim_val;

    function automatic logic [4:0] days_in_month(input logic [6:0] y, input logic [6:0] m);
        case (m)
            7'd2:                      return (y % 4 == 0) ? 5'd29 : 5'd28;
            7'd4, 7'd6, 7'd9, 7'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    always_comb begin
        bus.dim = days_in_month(bus.year, bus.month);
        if (dim_ovr) bus.dim = dim_val;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_date(input string tag, input exp_t e);
        check_val({tag, ".year"},  32'(bus.year),      32'(e.year));
        check_val({tag, ".month"}, 32'(bus.month),     32'(e.month));
        check_val({tag, ".day"},   32'(bus.day),       32'(e.day));
        check_val({tag, ".wday"},  32'(bus.wday),      32'(e.wday));
        check_val({tag, ".busy"},  32'(bus.busy),      32'(e.busy));
        check_val({tag, ".wrap"},  32'(bus.year_wrap), 32'(e.wrap));
    endtask

    // Drive one cycle of stimulus (inputs change at the falling edge), push
    // the expected post-edge state, then pop and compare at the next falling
    // edge.
    task automatic step(input string tag, input logic t, input logic l,
                        input int ly, input int lm, input int ld, input int lw,
                        input int ey, input int em, input int ed, input int ew,
                        input int eb, input int ewr);
        exp_t e;
        bus.tick       = t;
        bus.load       = l;
        bus.load_year  = 7'(ly);
        bus.load_month = 7'(lm);
        bus.load_day   = 5'(ld);
        bus.load_wday  = 3'(lw);
        e = '{year: ey, month: em, day: ed, wday: ew, busy: eb, wrap: ewr};
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.tick = 1'b0;
        bus.load = 1'b0;
        check_val({tag, ".sb_avail"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_date(tag, e);
        end
    endtask

    exp_t rst_exp;

    initial begin
        checks     = 0;
        failures   = 0;
        dim_ovr    = 1'b0;
        dim_val    = 5'd31;
        bus.tick   = 1'b0;
        bus.load   = 1'b0;
        bus.load_year  = '0;
        bus.load_month = '0;
        bus.load_day   = '0;
        bus.load_wday  = '0;
        rst_exp = '{year: 0, month: 1, day: 1, wday: 6, busy: 0, wrap: 0};
        rst_n = 1'b0;

        repeat (3) @(negedge clk);
        check_date("reset", rst_exp);
        rst_n = 1'b1;

        // First edge after reset accepts a tick.
        step("tick_after_rst", 1, 0, 0, 0, 0, 0,    0, 1, 2, 0, 0, 0);

        // Non-leap February end.
        step("ld_3_2_28",      0, 1, 3, 2, 28, 2,   3, 2, 28, 2, 1, 0);
        step("chk_3_2_28",     0, 0, 0, 0, 0, 0,    3, 2, 28, 2, 0, 0);
        step("tick_3_3_1",     1, 0, 0, 0, 0, 0,    3, 3, 1, 3, 0, 0);

        // Leap February end.
        step("ld_4_2_28",      0, 1, 4, 2, 28, 4,   4, 2, 28, 4, 1, 0);
        step("chk_4_2_28",     0, 0, 0, 0, 0, 0,    4, 2, 28, 4, 0, 0);
        step("tick_4_2_29",    1, 0, 0, 0, 0, 0,    4, 2, 29, 5, 0, 0);
        step("tick_4_3_1",     1, 0, 0, 0, 0, 0,    4, 3, 1, 6, 0, 0);

        // Day beyond dim clamped in CHECK.
        step("ld_4_2_31",      0, 1, 4, 2, 31, 1,   4, 2, 31, 1, 1, 0);
        step("chk_clamp",      0, 0, 0, 0, 0, 0,    4, 2, 29, 1, 0, 0);

        // Year wrap, pulse lasts exactly one cycle.
        step("ld_99_12_31",    0, 1, 99, 12, 31, 5, 99, 12, 31, 5, 1, 0);
        step("chk_99_12_31",   0, 0, 0, 0, 0, 0,    99, 12, 31, 5, 0, 0);
        step("tick_wrap",      1, 0, 0, 0, 0, 0,    0, 1, 1, 6, 0, 1);
        step("wrap_drop",      0, 0, 0, 0, 0, 0,    0, 1, 1, 6, 0, 0);

        // Tick with load pends; a second tick during CHECK is discarded.
        step("ld_tick_20",     1, 1, 20, 1, 31, 3,  20, 1, 31, 3, 1, 0);
        step("chk_tick_drop",  1, 0, 0, 0, 0, 0,    20, 1, 31, 3, 0, 0);
        step("pend_apply",     0, 0, 0, 0, 0, 0,    20, 2, 1, 4, 0, 0);
        step("no_extra_tick",  0, 0, 0, 0, 0, 0,    20, 2, 1, 4, 0, 0);

        // Pending tick first, a new tick in that cycle follows one edge later.
        step("ld_tick_20b",    1, 1, 20, 1, 31, 3,  20, 1, 31, 3, 1, 0);
        step("chk_20b",        0, 0, 0, 0, 0, 0,    20, 1, 31, 3, 0, 0);
        step("pend_and_new",   1, 0, 0, 0, 0, 0,    20, 2, 1, 4, 0, 0);
        step("new_follows",    0, 0, 0, 0, 0, 0,    20, 2, 2, 5, 0, 0);
        step("settled_20b",    0, 0, 0, 0, 0, 0,    20, 2, 2, 5, 0, 0);

        // Load during CHECK ignored.
        step("ld_10_5_5",      0, 1, 10, 5, 5, 1,   10, 5, 5, 1, 1, 0);
        step("ld_in_check",    0, 1, 30, 7, 9, 4,   10, 5, 5, 1, 0, 0);

        // Sanitising of every field.
        step("ld_insane",      0, 1, 120, 13, 0, 7, 0, 1, 1, 0, 1, 0);
        step("chk_insane",     0, 0, 0, 0, 0, 0,    0, 1, 1, 0, 0, 0);

        // Defensive roll: day above dim in IDLE moves to the next month.
        step("ld_5_1_31",      0, 1, 5, 1, 31, 2,   5, 1, 31, 2, 1, 0);
        step("chk_5_1_31",     0, 0, 0, 0, 0, 0,    5, 1, 31, 2, 0, 0);
        dim_ovr = 1'b1;
        dim_val = 5'd30;
        step("defensive_roll", 1, 0, 0, 0, 0, 0,    5, 2, 1, 3, 0, 0);
        dim_ovr = 1'b0;

        // Asynchronous reset in the middle of CHECK with a pending tick.
        step("ld_7_6_15",      1, 1, 7, 6, 15, 2,   7, 6, 15, 2, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_date("async_rst", rst_exp);
        @(negedge clk);
        rst_n = 1'b1;
        step("no_pend_after",  0, 0, 0, 0, 0, 0,    0, 1, 1, 6, 0, 0);
        step("tick_post_rst",  1, 0, 0, 0, 0, 0,    0, 1, 2, 0, 0, 0);

        check_val("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calendar_counter.md
CALENDAR_COUNTER -- requirements
Module: calendar_counter

Interface
REQ-001 Parameter: YEAR_MAX, default 99, highest year value before wrap to 0 (year 0 = 2000).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tick  input  1  one-cycle pulse: advance date by one day.
REQ-005 load  input  1  one-cycle pulse: load date from load_* fields.
REQ-006 load_year  input  7  year to load, 0..YEAR_MAX.
REQ-007 load_month  input  7  month to load, 1..12.
REQ-008 load_day  input  5  day to load, 1..31.
REQ-009 load_wday  input  3  weekday to load, 0 = Sunday .. 6 = Saturday.
REQ-010 dim  input  5  days in month for the current year/month outputs, from the external days-in-month lookup (combinational, leap when year%4==0).
REQ-011 year  output  7  current year, registered.
REQ-012 month  output  7  current month 1..12, registered.
REQ-013 day  output  5  current day 1..dim, registered.
REQ-014 wday  output  3  current weekday 0..6, registered.
REQ-015 busy  output  1  high during the load-check cycle.
REQ-016 year_wrap  output  1  one-cycle pulse when year wraps YEAR_MAX -> 0.

Function
REQ-017 The FSM SHALL have two states: IDLE and CHECK; reset state IDLE.
REQ-018 IDLE with tick=1 and load=0: SHALL advance the date on that edge; new values visible after the edge (latency 1).
REQ-019 Advance: day<dim -> day+1; else day=1 and month advances.
REQ-020 Month advance: month<12 -> month+1; else month=1 and year advances.
REQ-021 Year advance: year==YEAR_MAX -> year=0 with year_wrap=1 for exactly one cycle; else year+1.
REQ-022 Every advance SHALL step wday: 6 -> 0, else wday+1.
REQ-023 Defensive: in IDLE, day>dim on tick SHALL be treated as day==dim (rolls to next month).
REQ-024 IDLE with load=1: SHALL capture load_* fields, sanitised as follows, and go to CHECK.
REQ-025 Sanitise month: 0 or >12 -> 1.
REQ-026 Sanitise year: >YEAR_MAX -> 0.
REQ-027 Sanitise day: 0 -> 1.
REQ-028 Sanitise wday: >6 -> 0.
REQ-029 CHECK (busy=1, exactly one cycle): day>dim -> day=dim; then return to IDLE.
REQ-030 CHECK SHALL not alter year, month or wday.
REQ-031 tick arriving with load in IDLE, or during CHECK, SHALL set a single pending flag; ticks are not otherwise dropped.
REQ-032 Further ticks while the pending flag is set SHALL be discarded.
REQ-033 Pending tick SHALL be applied on the first IDLE cycle after CHECK, and the flag cleared.
REQ-034 Pending tick takes precedence over a new tick in that same cycle; the new tick is applied on the following cycle.
REQ-035 load during CHECK SHALL be ignored.
REQ-036 year_wrap SHALL be 0 on every cycle not covered by REQ-021.

Reset
REQ-037 rst_n low SHALL immediately force: year=0, month=1, day=1, wday=6, busy=0, year_wrap=0, pending=0, state IDLE.
REQ-038 Reset mid-CHECK SHALL discard the captured load and any pending tick.
REQ-039 After rst_n rises, the first edge SHALL accept tick/load normally.

Verification
REQ-040 Reset -> outputs 0/1/1, wday=6, busy=0, year_wrap=0; assert rst_n mid-CHECK -> same values asynchronously, no clock needed.
REQ-041 Load 3/2/28 (dim=28) then tick -> 3/3/1; load 4/2/28 (dim=29) then tick -> 4/2/29; tick again -> 4/3/1.
REQ-042 Load year 4, month 2, day 31 -> after load edge day=31, busy=1; after CHECK edge day=29, busy=0.
REQ-043 Load 99/12/31, wday=5, then tick -> 0/1/1, wday=6, year_wrap high exactly one cycle.
REQ-044 Load 20/1/31 with tick in same cycle -> CHECK cycle, then 20/2/1 one edge later; a second tick during CHECK is discarded (single pending).
REQ-045 Load month 13, day 0, wday 7, year 120 -> 0/1/1, wday=0 after CHECK.
